mtl_frame_writer: RTL and testbench
===================================

# mtl_frame_writer

Write-side counterpart of the LCD display controller. Accepts a full 800×480 frame of 32-bit RGB pixel words from the SPI command/data path, buffers them in a small FIFO, and pushes them into the SDRAM controller write port. It also generates the `oLoading` handshake consumed by the display controller's `iLoading` input, so the display shows the loading screen while a frame is being written and switches to SDRAM data afterwards.

## Interface
Parameters:
- `H_ACTIVE`, 800, active pixels per line
- `V_ACTIVE`, 480, active lines per frame
- `FIFO_DEPTH`, 16, internal pixel FIFO depth in words; power of two, at least 4

Ports:
- `iCLK`  in  1  clock; same LCD/pixel clock as the display controller
- `iRST_n`  in  1  reset, asynchronous, active-low
- `iStart`  in  1  one-cycle pulse from the SPI decoder; begins a frame load
- `iPIX_DATA`  in  32  pixel word, `[23:16]`=R, `[15:8]`=G, `[7:0]`=B, `[31:24]` ignored
- `iPIX_VALID`  in  1  `iPIX_DATA` valid
- `oPIX_READY`  out  1  FIFO can accept a word this cycle
- `oWRITE_DATA`  out  32  word to the SDRAM write FIFO; `[31:24]` forced to 0
- `oWRITE_SDRAM_EN`  out  1  SDRAM write strobe; one word per high cycle
- `iWRITE_FULL`  in  1  SDRAM write FIFO full; back-pressure
- `oWR_LOAD`  out  1  one-cycle pulse that reloads the SDRAM write address to frame base
- `iEnd_Frame`  in  1  end-of-frame pulse from the display controller
- `oLoading`  out  1  frame load in progress; drives the display's `iLoading`
- `oDone`  out  1  one-cycle pulse when the frame is committed
- `oX`  out  10  column of the next word to write, 0..`H_ACTIVE`-1
- `oY`  out  9  line of the next word to write, 0..`V_ACTIVE`-1

## Operation
- States:
  - `IDLE`
    - `iStart` → `CLEAR`.
  - `CLEAR`
    - Lasts 1 cycle and asserts `oWR_LOAD`.
    - Clears the accepted-word counter, `oX` and `oY`.
    - Next state is `LOAD`.
  - `LOAD`
    - Accepts pixels while accepted count < `H_ACTIVE`×`V_ACTIVE` (384000).
    - When the last word is accepted → `FLUSH`.
  - `FLUSH`
    - `oPIX_READY`=0.
    - Stays until the FIFO is empty → `WAIT_FRAME`.
  - `WAIT_FRAME`
    - Waits for `iEnd_Frame` → `DONE`.
    - If `iEnd_Frame` is high on the cycle `WAIT_FRAME` is entered, it does not count.
  - `DONE`
    - Lasts 1 cycle and pulses `oDone`.
    - Next state is `IDLE`.
- `oLoading`=1 in `CLEAR`, `LOAD`, `FLUSH` and `WAIT_FRAME`; 0 in `IDLE` and `DONE`.
- `iStart` is ignored in every state except `IDLE`.
- Accept (FIFO push):
  - `oPIX_READY` = (state==`LOAD`) && !fifo_full && (accepted < 384000).
  - A push happens when `iPIX_VALID` && `oPIX_READY`.
- Drain (FIFO pop):
  - `oWRITE_SDRAM_EN` = (state is `LOAD` or `FLUSH`) && !fifo_empty && !`iWRITE_FULL`.
  - `oWRITE_DATA` is the FIFO head (show-ahead), so a pop happens exactly when `oWRITE_SDRAM_EN`=1.
- Simultaneous push and pop: occupancy is unchanged. Push while full is impossible because `oPIX_READY`=0.
- `oX`/`oY` advance on each pop:
  - `oX` wraps at `H_ACTIVE`-1 to 0 and increments `oY`.
  - After the 384000th pop they read (0,0).
- Counter widths:
  - Accepted counter is 19 bits, saturating at 384000.
  - FIFO count is log2(`FIFO_DEPTH`)+1 bits.

## Timing
- Reset values: `oPIX_READY`=0, `oWRITE_SDRAM_EN`=0, `oWRITE_DATA`=0, `oWR_LOAD`=0, `oLoading`=0, `oDone`=0, `oX`=0, `oY`=0. The state machine resets to `IDLE` and the FIFO resets empty.
- `iStart` at cycle N:
  - `oWR_LOAD`=1 and `oLoading`=1 at N+1.
  - `oPIX_READY` can be 1 from N+2.
- A word pushed at cycle N can appear on `oWRITE_DATA` with `oWRITE_SDRAM_EN`=1 at N+1 at the earliest. FIFO write-to-read latency is 1 cycle.
- With `iWRITE_FULL` held 0 and `iPIX_VALID` held 1, throughput is 1 word per cycle.
- `oLoading` falls on the cycle after the qualifying `iEnd_Frame`, the same cycle `oDone` pulses. The display then leaves the loading screen at its next new frame.
- Reset asserted mid-load:
  - All outputs return to their reset values immediately.
  - FIFO contents are discarded.
  - The partially written frame in SDRAM is left as is.

## Structure
- Shared package `mtl_pkg`:
  - `H_ACTIVE`, `V_ACTIVE`, `FRAME_PIXELS`=384000.
  - The state enum `writer_state_t` {`IDLE`, `CLEAR`, `LOAD`, `FLUSH`, `WAIT_FRAME`, `DONE`}.
  - The RGB word field positions, shared with the display controller.
- Sub-module `pixel_fifo`:
  - Synchronous show-ahead FIFO, parameterised by width and depth.
  - Ports: push, pop, din, dout, full, empty, count.
- The state machine, counters and `oX`/`oY` stay in the top level.

## Test plan
- Reset with `iPIX_VALID`=1 → all outputs 0 and state `IDLE`. Then `iStart` → `oWR_LOAD` 1 cycle and `oLoading`=1 next cycle.
- Stream 384000 words 0x00000000..0x0005DBFF with `iWRITE_FULL`=0 → every word appears once, in order, with `[31:24]`=0. `oPIX_READY` drops after the 384000th accept. After the last pop, `oX`/`oY` return to 0/0.
- Hold `iWRITE_FULL`=1 for 40 cycles mid-frame → FIFO fills to 16, `oPIX_READY`=0, no data loss. On release, the drain resumes in order.
- Random `iPIX_VALID`/`iWRITE_FULL` with `H_ACTIVE`=8, `V_ACTIVE`=4 → 32 words written in order. `oX` wraps 7→0 and `oY` increments.
- Frame complete, `iEnd_Frame` 5 cycles later → `oDone` pulse and `oLoading`=0 on the cycle after `iEnd_Frame`. A second `iStart` pulsed during `LOAD` is ignored.
- Reset asserted after 1000 words → immediate return to reset values. A new `iStart` restarts at `oX`=0 with a fresh `oWR_LOAD`.

Source files
------------

// File: rtl/mtl_pkg.sv
// Shared definitions for the MTL display path: frame geometry, frame-writer
// states and the RGB field layout of a 32-bit pixel word.
package mtl_pkg;

    localparam int unsigned H_ACTIVE     = 800;
    localparam int unsigned V_ACTIVE     = 480;
    localparam int unsigned FRAME_PIXELS = H_ACTIVE * V_ACTIVE;

    // Accepted-word counter must hold FRAME_PIXELS (384000 < 2**19).
    localparam int unsigned PIX_CNT_W = 19;

    // RGB word layout; bits above RGB_W carry no colour information.
    localparam int unsigned RGB_R_MSB = 23;
    localparam int unsigned RGB_R_LSB = 16;
    localparam int unsigned RGB_G_MSB = 15;
    localparam int unsigned RGB_G_LSB = 8;
    localparam int unsigned RGB_B_MSB = 7;
    localparam int unsigned RGB_B_LSB = 0;
    localparam int unsigned RGB_W     = 24;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        FLUSH,
        WAIT_FRAME,
        DONE
    } writer_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous show-ahead FIFO: dout_o always presents the head entry, and a
// pop simply advances past it. Storage is not reset; only pointers/count are.
module pixel_fifo #(
    parameter int unsigned Width = 24,
    parameter int unsigned Depth = 16,
    localparam int unsigned AddrW = $clog2(Depth),
    localparam int unsigned CntW  = AddrW + 1
) (
    input  logic             iCLK,
    input  logic             iRST_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] din_i,
    output logic [Width-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // Guard against misuse so occupancy can never over/underflow.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Occupancy update; simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage write; Depth is a power of two so pointers wrap naturally.
    always_ff @(posedge iCLK) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mtl_frame_writer.sv
// Frame writer: accepts one frame of pixel words, buffers them in a small
// FIFO and streams them into the SDRAM write port, while holding oLoading so
// the display shows its loading screen until the frame is committed.
module mtl_frame_writer #(
    parameter int unsigned H_ACTIVE   = mtl_pkg::H_ACTIVE,
    parameter int unsigned V_ACTIVE   = mtl_pkg::V_ACTIVE,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iStart,
    input  logic [31:0] iPIX_DATA,
    input  logic        iPIX_VALID,
    output logic        oPIX_READY,
    output logic [31:0] oWRITE_DATA,
    output logic        oWRITE_SDRAM_EN,
    input  logic        iWRITE_FULL,
    output logic        oWR_LOAD,
    input  logic        iEnd_Frame,
    output logic        oLoading,
    output logic        oDone,
    output logic [9:0]  oX,
    output logic [8:0]  oY
);

    import mtl_pkg::*;

    localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PIX_CNT_W-1:0] FrameWords = PIX_CNT_W'(H_ACTIVE * V_ACTIVE);
    localparam logic [9:0] XLast = 10'(H_ACTIVE - 1);
    localparam logic [8:0] YLast = 9'(V_ACTIVE - 1);

    writer_state_t        state_q, state_d;
    logic [PIX_CNT_W-1:0] accepted_q, accepted_d;
    logic [9:0]           x_q, x_d;
    logic [8:0]           y_q, y_d;
    logic                 armed_q;

    logic                 push, pop;
    logic                 fifo_full, fifo_empty;
    logic [RGB_W-1:0]     fifo_dout;
    logic [FifoCntW-1:0]  fifo_count;

    // Alpha byte is carried on the bus but never stored.
    logic unused_alpha;
    assign unused_alpha = ^iPIX_DATA[31:RGB_W];

    pixel_fifo #(
        .Width (RGB_W),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .iCLK    (iCLK),
        .iRST_n  (iRST_n),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (iPIX_DATA[RGB_W-1:0]),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Handshakes and status outputs, all decoded from the current state.
    always_comb begin
        oPIX_READY      = (state_q == LOAD) && !fifo_full && (accepted_q < FrameWords);
        oWRITE_SDRAM_EN = ((state_q == LOAD) || (state_q == FLUSH)) && !fifo_empty
                          && !iWRITE_FULL;
        oWRITE_DATA     = fifo_empty ? 32'h0 : {{(32 - RGB_W){1'b0}}, fifo_dout};
        oWR_LOAD        = (state_q == CLEAR);
        oDone           = (state_q == DONE);
        oLoading        = (state_q == CLEAR) || (state_q == LOAD) || (state_q == FLUSH)
                          || (state_q == WAIT_FRAME);
        oX              = x_q;
        oY              = y_q;
        push            = iPIX_VALID && oPIX_READY;
        pop             = oWRITE_SDRAM_EN;
    end

    // Next-state logic for the frame-load sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (iStart) state_d = CLEAR;
            CLEAR:      state_d = LOAD;
            LOAD:       if (push && (accepted_q == FrameWords - 1'b1)) state_d = FLUSH;
            FLUSH:      if (fifo_count == '0) state_d = WAIT_FRAME;
            // armed_q is low on the entry cycle, so a coincident end-of-frame is skipped.
            WAIT_FRAME: if (iEnd_Frame && armed_q) state_d = DONE;
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Accepted-word counter and write-position counters.
    always_comb begin
        accepted_d = accepted_q;
        x_d        = x_q;
        y_d        = y_q;
        if (state_q == CLEAR) begin
            accepted_d = '0;
            x_d        = '0;
            y_d        = '0;
        end else begin
            if (push) accepted_d = accepted_q + 1'b1;
            if (pop) begin
                if (x_q == XLast) begin
                    x_d = '0;
                    y_d = (y_q == YLast) ? '0 : y_q + 1'b1;
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q    <= IDLE;
            accepted_q <= '0;
            x_q        <= '0;
            y_q        <= '0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            accepted_q <= accepted_d;
            x_q        <= x_d;
            y_q        <= y_d;
            armed_q    <= (state_q == WAIT_FRAME);
        end
    end

endmodule

// File: tb/tb_mtl_frame_writer.sv
// Directed bench for mtl_frame_writer using a reduced 8x4 frame.
`timescale 1ns/1ps
module tb_mtl_frame_writer;

    localparam int unsigned H = 8;
    localparam int unsigned V = 4;
    localparam int unsigned N = H * V;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        pix_valid = 1'b0;
    logic        write_full = 1'b0;
    logic        end_frame = 1'b0;
    logic [31:0] pix_data;
    logic        pix_ready;
    logic [31:0] write_data;
    logic        write_en;
    logic        wr_load;
    logic        loading;
    logic        done;
    logic [9:0]  x;
    logic [8:0]  y;

    int checks = 0;
    int errors = 0;
    int frame_id = 0;
    int p_id = 0;
    int m_id = 0;
    int fpush = 0;
    int fpop = 0;
    bit will_push = 1'b0;

    always #5 clk = ~clk;

    mtl_frame_writer #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .FIFO_DEPTH (16)
    ) dut (
        .iCLK            (clk),
        .iRST_n          (rst_n),
        .iStart          (start),
        .iPIX_DATA       (pix_data),
        .iPIX_VALID      (pix_valid),
        .oPIX_READY      (pix_ready),
        .oWRITE_DATA     (write_data),
        .oWRITE_SDRAM_EN (write_en),
        .iWRITE_FULL     (write_full),
        .oWR_LOAD        (wr_load),
        .iEnd_Frame      (end_frame),
        .oLoading        (loading),
        .oDone           (done),
        .oX              (x),
        .oY              (y)
    );

    // Pixel word: junk alpha byte, frame tag, index within frame.
    assign pix_data = {8'hA5, 8'(p_id), 16'(fpush)};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Source side: advance the word index after each accepted word.
    always @(posedge clk) begin
        #1;
        if (p_id != frame_id) begin
            p_id  = frame_id;
            fpush = 0;
        end else if (will_push) begin
            fpush++;
        end
    end

    // Sink side: every popped word must be the next one in order, alpha cleared.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_id != frame_id) begin
                m_id = frame_id;
                fpop = 0;
            end
            will_push = pix_valid && pix_ready;
            if (write_en) begin
                chk("pop_data", write_data, {8'h00, 8'(m_id), 16'(fpop)});
                chk("pop_x", 32'(x), 32'(fpop % H));
                chk("pop_y", 32'(y), 32'(fpop / H));
                fpop++;
            end
        end else begin
            will_push = 1'b0;
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(pix_ready), 32'd0);
        chk({tag, "_wen"}, 32'(write_en), 32'd0);
        chk({tag, "_wdata"}, write_data, 32'd0);
        chk({tag, "_wrload"}, 32'(wr_load), 32'd0);
        chk({tag, "_loading"}, 32'(loading), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_x"}, 32'(x), 32'd0);
        chk({tag, "_y"}, 32'(y), 32'd0);
    endtask

    // Pulse iStart for one cycle; returns one cycle later, when CLEAR is active.
    task automatic start_frame();
        frame_id++;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("start_wrload", 32'(wr_load), 32'd1);
        chk("start_loading", 32'(loading), 32'd1);
        chk("start_ready", 32'(pix_ready), 32'd0);
    endtask

    task automatic wait_pops(input int budget);
        int n = 0;
        while (fpop < int'(N) && n < budget) begin
            cyc();
            n++;
        end
        chk("drain_done", 32'(fpop), N);
    endtask

    task automatic finish_frame();
        repeat (3) cyc();
        end_frame = 1'b1;
        cyc();
        end_frame = 1'b0;
        chk("fin_done", 32'(done), 32'd1);
        chk("fin_loading", 32'(loading), 32'd0);
        cyc();
        chk("fin_done_low", 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with valid held high.
        pix_valid = 1'b1;
        repeat (2) cyc();
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        cyc();
        chk("idle_ready", 32'(pix_ready), 32'd0);
        chk("idle_loading", 32'(loading), 32'd0);

        // Frame A: full throughput, stray iStart in LOAD, end-of-frame on entry.
        start_frame();
        cyc();
        chk("a_wrload_off", 32'(wr_load), 32'd0);
        chk("a_ready_on", 32'(pix_ready), 32'd1);
        chk("a_wen_first", 32'(write_en), 32'd0);
        cyc();
        chk("a_wen_next", 32'(write_en), 32'd1);
        repeat (5) cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("a_restart_ignored", 32'(wr_load), 32'd0);
        chk("a_restart_loading", 32'(loading), 32'd1);
        repeat (25) cyc();
        chk("a_ready_off", 32'(pix_ready), 32'd0);
        chk("a_pushed", 32'(fpush), N);
        chk("a_last_wen", 32'(write_en), 32'd1);
        chk("a_last_x", 32'(x), 32'd7);
        chk("a_last_y", 32'(y), 32'd3);
        cyc();
        chk("a_flush_wen", 32'(write_en), 32'd0);
        chk("a_popped", 32'(fpop), N);
        chk("a_wrap_x", 32'(x), 32'd0);
        chk("a_wrap_y", 32'(y), 32'd0);
        chk("a_flush_loading", 32'(loading), 32'd1);
        cyc();
        end_frame = 1'b1;
        cyc();
        end_frame = 1'b0;
        chk("a_entry_eof_done", 32'(done), 32'd0);
        chk("a_entry_eof_loading", 32'(loading), 32'd1);
        repeat (4) cyc();
        end_frame = 1'b1;
        cyc();
        end_frame = 1'b0;
        chk("a_done", 32'(done), 32'd1);
        chk("a_loading_off", 32'(loading), 32'd0);
        cyc();
        chk("a_done_low", 32'(done), 32'd0);
        chk("a_idle_loading", 32'(loading), 32'd0);

        // Frame B: 40-cycle SDRAM back-pressure mid-frame.
        start_frame();
        cyc();
        repeat (4) cyc();
        write_full = 1'b1;
        repeat (39) cyc();
        chk("b_stall_ready", 32'(pix_ready), 32'd0);
        chk("b_stall_wen", 32'(write_en), 32'd0);
        chk("b_stall_pushed", 32'(fpush), 32'd19);
        chk("b_stall_occupancy", 32'(fpush - fpop), 32'd16);
        write_full = 1'b0;
        wait_pops(100);
        finish_frame();

        // Frame C: random valid / back-pressure.
        start_frame();
        for (int i = 0; i < 400 && fpop < int'(N); i++) begin
            pix_valid  = 1'($urandom_range(0, 1));
            write_full = ($urandom_range(0, 3) == 0);
            cyc();
        end
        pix_valid  = 1'b1;
        write_full = 1'b0;
        wait_pops(100);
        chk("c_ready_off", 32'(pix_ready), 32'd0);
        chk("c_end_x", 32'(x), 32'd0);
        chk("c_end_y", 32'(y), 32'd0);
        finish_frame();

        // Frame D: reset mid-load with words still buffered, then a clean restart.
        start_frame();
        cyc();
        repeat (6) cyc();
        write_full = 1'b1;
        repeat (4) cyc();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        cyc();
        cyc();
        rst_n      = 1'b1;
        write_full = 1'b0;
        cyc();
        chk("d_idle_ready", 32'(pix_ready), 32'd0);
        start_frame();
        wait_pops(100);
        finish_frame();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
